alu_bus_ctrl: RTL

//   Narrow-bus front end for the N-bit logic element array. Receives a command beat and

---
 rtl/alu_bus_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_bus_ctrl.sv
// Narrow-bus front end for the N-bit logic element array: collects command and operands
// over a D-bit valid/ready bus, drives the array, and returns its result D bits per beat.
module alu_bus_ctrl #(
  parameter int N = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_abort,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [D-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [D-1:0] o_out_data,
  output logic         o_busy,
  output logic         o_alu_m,
  output logic [1:0]   o_alu_s,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  input  logic [N-1:0] i_alu_x
);

  localparam int BEATS = N / D;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_alu_m;
  logic [1:0]    r_alu_s;
  logic [N-1:0]  r_alu_a;
  logic [N-1:0]  r_alu_b;
  logic [N-1:0]  r_result;
  logic          r_out_valid;
  logic [D-1:0]  r_out_data;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_out_fire;
  logic          w_last;
  logic [CW-1:0] w_cnt_next;
  logic [D-1:0]  w_next_beat;

  assign w_in_ready = (r_state == S_IDLE) || (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & i_out_ready;
  assign w_last     = (r_cnt == LAST);
  assign w_cnt_next = r_cnt + CW'(1);

  // Result slice presented after the current beat is taken.
  always_comb begin
    w_next_beat = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (w_cnt_next == CW'(k)) w_next_beat = r_result[k*D +: D];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_alu_m     <= 1'b0;
      r_alu_s     <= 2'b00;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (i_abort) begin
      // Abort wins over any beat in the same cycle; array inputs and result are kept.
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            {r_alu_m, r_alu_s} <= i_in_data[2:0];
            r_cnt              <= '0;
            r_state            <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (w_accept) begin
            for (int k = 0; k < BEATS; k++) begin
              if (r_cnt == CW'(k)) r_alu_a[k*D +: D] <= i_in_data;
            end
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_B;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end
        end
        S_LOAD_B: begin
          if (w_accept) begin
            for (int k = 0; k < BEATS; k++) begin
              if (r_cnt == CW'(k)) r_alu_b[k*D +: D] <= i_in_data;
            end
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_EXEC;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end
        end
        S_EXEC: begin
          r_result    <= i_alu_x;
          r_out_data  <= i_alu_x[D-1:0];
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (w_out_fire) begin
            if (w_last) begin
              r_out_valid <= 1'b0;
              r_cnt       <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_cnt      <= w_cnt_next;
              r_out_data <= w_next_beat;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = (r_state != S_IDLE);
  assign o_alu_m     = r_alu_m;
  assign o_alu_s     = r_alu_s;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;

endmodule
